// File: rtl/cleaning_reminder_timer_pkg.sv
// Shared state encodings and default constants for the cleaning reminder timer.
package cleaning_reminder_timer_pkg;

  typedef enum logic [1:0] {
    ST_COUNTING = 2'd0,
    ST_ALERT    = 2'd1,
    ST_MUTED    = 2'd2
  } crt_state_e;

  localparam int unsigned DEF_TICK_DIV  = 100_000_000;
  localparam int unsigned DEF_BEEP_HALF = 50_000_000;
  localparam int unsigned DEF_MUTE_S    = 300;
  localparam int unsigned DEF_TIME_W    = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cleaning_reminder_timer_usage_tick_gen.sv
// Fan-gated prescaler: emits a one-cycle tick per TICK_DIV cycles of fan operation.
module usage_tick_gen
  import cleaning_reminder_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic fan_on,
  output logic tick_c
);

  localparam int unsigned PW = cnt_w(TICK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          at_wrap;

  assign at_wrap = (pre_cnt == PW'(TICK_DIV - 1));
  assign tick_c  = fan_on && at_wrap;

  // Count holds while the fan is off so partial seconds are not lost.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pre_cnt <= '0;
    end else if (fan_on) begin
      if (at_wrap) pre_cnt <= '0;
      else         pre_cnt <= pre_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/cleaning_reminder_timer.sv
// Fan run-time accounting with threshold alert, 1 Hz beep cadence, mute re-arm and clean acknowledge.
module cleaning_reminder_timer
  import cleaning_reminder_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned BEEP_HALF = DEF_BEEP_HALF,
  parameter int unsigned MUTE_S    = DEF_MUTE_S,
  parameter int unsigned TIME_W    = DEF_TIME_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fan_on,
  input  logic [TIME_W-1:0] threshold_s,
  input  logic              mute_btn,
  input  logic              clean_btn,
  output logic              cleaning_reminder,
  output logic              alert_led,
  output logic [TIME_W-1:0] usage_s,
  output logic [1:0]        state_o
);

  localparam int unsigned BW = cnt_w(BEEP_HALF);
  localparam int unsigned MW = cnt_w(MUTE_S + 1);

  crt_state_e        state, state_nxt;
  logic [TIME_W-1:0] usage_nxt;
  logic [BW-1:0]     beep_cnt, beep_cnt_nxt;
  logic              beep_phase, beep_phase_nxt;
  logic [MW-1:0]     mute_cnt, mute_cnt_nxt;
  logic              mute_q, clean_q;
  logic              mute_edge_c, clean_edge_c;
  logic              tick_c;
  logic              reminder_nxt, led_nxt;

  assign mute_edge_c  = mute_btn & ~mute_q;
  assign clean_edge_c = clean_btn & ~clean_q;
  assign state_o      = state;

  usage_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clean_edge_c),
    .fan_on (fan_on),
    .tick_c (tick_c)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_COUNTING;
      usage_s           <= '0;
      beep_cnt          <= '0;
      beep_phase        <= 1'b0;
      mute_cnt          <= '0;
      mute_q            <= 1'b0;
      clean_q           <= 1'b0;
      cleaning_reminder <= 1'b0;
      alert_led         <= 1'b0;
    end else begin
      state             <= state_nxt;
      usage_s           <= usage_nxt;
      beep_cnt          <= beep_cnt_nxt;
      beep_phase        <= beep_phase_nxt;
      mute_cnt          <= mute_cnt_nxt;
      mute_q            <= mute_btn;
      clean_q           <= clean_btn;
      cleaning_reminder <= reminder_nxt;
      alert_led         <= led_nxt;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt      = state;
    usage_nxt      = usage_s;
    beep_cnt_nxt   = beep_cnt;
    beep_phase_nxt = beep_phase;
    mute_cnt_nxt   = mute_cnt;

    if (tick_c && (usage_s != '1)) usage_nxt = usage_s + TIME_W'(1);

    case (state)
      ST_COUNTING: begin
        beep_cnt_nxt   = '0;
        beep_phase_nxt = 1'b0;
        mute_cnt_nxt   = '0;
        if ((threshold_s != '0) && (usage_s >= threshold_s)) begin
          state_nxt      = ST_ALERT;
          beep_phase_nxt = 1'b1;
        end
      end
      ST_ALERT: begin
        if (mute_edge_c) begin
          state_nxt    = ST_MUTED;
          mute_cnt_nxt = '0;
        end else if (beep_cnt == BW'(BEEP_HALF - 1)) begin
          beep_cnt_nxt   = '0;
          beep_phase_nxt = ~beep_phase;
        end else begin
          beep_cnt_nxt = beep_cnt + BW'(1);
        end
      end
      ST_MUTED: begin
        // The re-arm fires on the tick that brings the mute count to MUTE_S.
        if (tick_c) begin
          if (mute_cnt == MW'(MUTE_S - 1)) begin
            state_nxt      = ST_ALERT;
            beep_cnt_nxt   = '0;
            beep_phase_nxt = 1'b1;
            mute_cnt_nxt   = '0;
          end else begin
            mute_cnt_nxt = mute_cnt + MW'(1);
          end
        end
      end
      default: begin
        state_nxt      = ST_COUNTING;
        beep_cnt_nxt   = '0;
        beep_phase_nxt = 1'b0;
        mute_cnt_nxt   = '0;
      end
    endcase

    if (clean_edge_c) begin
      state_nxt      = ST_COUNTING;
      usage_nxt      = '0;
      beep_cnt_nxt   = '0;
      beep_phase_nxt = 1'b0;
      mute_cnt_nxt   = '0;
    end

    reminder_nxt = (state_nxt == ST_ALERT) && beep_phase_nxt;
    led_nxt      = (state_nxt != ST_COUNTING);
  end

endmodule

// File: tb/tb_cleaning_reminder_timer.sv
// Directed bench: reduced timing constants, a 32-bit main instance and a 4-bit saturation instance.
module tb_cleaning_reminder_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fan_on;
  logic [31:0] threshold_s;
  logic        mute_btn;
  logic        clean_btn;
  logic        cleaning_reminder;
  logic        alert_led;
  logic [31:0] usage_s;
  logic [1:0]  state_o;

  logic        sat_reminder;
  logic        sat_led;
  logic [3:0]  sat_usage;
  logic [1:0]  sat_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cleaning_reminder_timer #(
    .TICK_DIV (10), .BEEP_HALF (4), .MUTE_S (3), .TIME_W (32)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fan_on            (fan_on),
    .threshold_s       (threshold_s),
    .mute_btn          (mute_btn),
    .clean_btn         (clean_btn),
    .cleaning_reminder (cleaning_reminder),
    .alert_led         (alert_led),
    .usage_s           (usage_s),
    .state_o           (state_o)
  );

  cleaning_reminder_timer #(
    .TICK_DIV (10), .BEEP_HALF (4), .MUTE_S (3), .TIME_W (4)
  ) u_sat (
    .clk               (clk),
    .rst_n             (rst_n),
    .fan_on            (fan_on),
    .threshold_s       (4'd0),
    .mute_btn          (1'b0),
    .clean_btn         (1'b0),
    .cleaning_reminder (sat_reminder),
    .alert_led         (sat_led),
    .usage_s           (sat_usage),
    .state_o           (sat_state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fan_on = 1'b0; threshold_s = 32'd5; mute_btn = 1'b0; clean_btn = 1'b0;
    step(3);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_usage", usage_s, 32'd0);
    chk("rst_reminder", 32'(cleaning_reminder), 32'd0);
    chk("rst_led", 32'(alert_led), 32'd0);
    rst_n = 1'b1;

    fan_on = 1'b1;
    step(49);
    chk("run49_usage", usage_s, 32'd4);
    chk("run49_state", 32'(state_o), 32'd0);
    chk("run49_reminder", 32'(cleaning_reminder), 32'd0);
    chk("run49_sat_usage", 32'(sat_usage), 32'd4);
    step(1);
    chk("run50_usage", usage_s, 32'd5);
    chk("run50_state", 32'(state_o), 32'd0);
    fan_on = 1'b0;

    step(1);
    chk("alert_state", 32'(state_o), 32'd1);
    chk("alert_led", 32'(alert_led), 32'd1);
    chk("alert_first_beep", 32'(cleaning_reminder), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      step(1);
      chk("cadence", 32'(cleaning_reminder), (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("alert_usage_frozen", usage_s, 32'd5);

    mute_btn = 1'b1;
    step(1);
    chk("muted_state", 32'(state_o), 32'd2);
    chk("muted_reminder", 32'(cleaning_reminder), 32'd0);
    chk("muted_led", 32'(alert_led), 32'd1);
    mute_btn = 1'b0;
    fan_on = 1'b1;
    step(29);
    chk("muted29_state", 32'(state_o), 32'd2);
    chk("muted29_usage", usage_s, 32'd7);
    chk("muted29_reminder", 32'(cleaning_reminder), 32'd0);
    step(1);
    chk("rearm_state", 32'(state_o), 32'd1);
    chk("rearm_reminder", 32'(cleaning_reminder), 32'd1);
    chk("rearm_usage", usage_s, 32'd8);
    fan_on = 1'b0;

    mute_btn = 1'b1; clean_btn = 1'b1;
    step(1);
    chk("clean_state", 32'(state_o), 32'd0);
    chk("clean_usage", usage_s, 32'd0);
    chk("clean_reminder", 32'(cleaning_reminder), 32'd0);
    chk("clean_led", 32'(alert_led), 32'd0);
    mute_btn = 1'b0; clean_btn = 1'b0;

    threshold_s = 32'd0; fan_on = 1'b1;
    step(200);
    chk("thr0_usage", usage_s, 32'd20);
    chk("thr0_state", 32'(state_o), 32'd0);
    chk("thr0_led", 32'(alert_led), 32'd0);
    threshold_s = 32'd15;
    step(1);
    chk("thr15_state", 32'(state_o), 32'd1);
    chk("thr15_reminder", 32'(cleaning_reminder), 32'd1);
    chk("thr15_usage", usage_s, 32'd20);
    fan_on = 1'b0;

    threshold_s = 32'd100;
    step(3);
    chk("thr_raise_keeps_alert", 32'(state_o), 32'd1);
    chk("thr_raise_led", 32'(alert_led), 32'd1);

    chk("sat_usage", 32'(sat_usage), 32'd15);
    chk("sat_state", 32'(sat_state), 32'd0);
    chk("sat_led", 32'(sat_led), 32'd0);

    rst_n = 1'b0;
    step(1);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_reminder", 32'(cleaning_reminder), 32'd0);
    chk("midrst_led", 32'(alert_led), 32'd0);
    chk("midrst_usage", usage_s, 32'd0);
    chk("midrst_sat_usage", 32'(sat_usage), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cleaning_reminder_timer.md
Name: cleaning_reminder_timer

Overview:
- Upstream stage of sound_reminder. Accumulates range-hood fan run time in seconds.
- Raises cleaning_reminder when run time reaches a programmable threshold. Output is a 1 Hz on/off beep cadence, fed directly into sound_reminder's cleaning_reminder input.
- Handles a user mute, with automatic re-arm, and a "cleaning done" acknowledge that restarts accounting.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per counted second of fan operation.
- BEEP_HALF, 50_000_000, clk cycles per beep phase (on or off).
- MUTE_S, 300, seconds of further fan operation before a muted alert re-sounds.
- TIME_W, 32, width of the usage/threshold counters.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  synchronous active-low reset.
- fan_on  input  1  level: fan currently running; run time accrues only while high.
- threshold_s  input  TIME_W  reminder threshold in seconds; 0 disables alerts.
- mute_btn  input  1  debounced level; rising edge = mute request.
- clean_btn  input  1  debounced level; rising edge = cleaning done.
- cleaning_reminder  output  1  beep-cadence enable to sound_reminder.
- alert_led  output  1  high while an alert is pending (ALERT or MUTED).
- usage_s  output  TIME_W  accumulated run seconds since last clean.
- state_o  output  2  current state encoding, for display/debug.

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=COUNTING; usage_s=0; prescaler, cadence and mute counters = 0.
  - Edge-detect registers = 0; cleaning_reminder=0; alert_led=0.
- Edge detection: edge = btn & ~btn_q, with btn_q registered each cycle. All effects appear on the cycle after the input rises.
- Prescaler:
  - Advances only when fan_on=1; holds its value when fan_on=0.
  - At TICK_DIV-1 it wraps to 0 and emits a 1-cycle tick.
- usage_s:
  - Increments on tick.
  - Saturates at all-ones; never wraps.
- States:
  - COUNTING: outputs 0. If threshold_s!=0 and usage_s>=threshold_s, go to ALERT next cycle. mute edge is ignored.
  - ALERT:
    - Cadence counter runs every cycle, independent of fan_on. It wraps at BEEP_HALF-1 and toggles phase on wrap.
    - Phase=1 on entry, so cleaning_reminder=1 on the first ALERT cycle; cleaning_reminder=phase; alert_led=1.
    - mute edge -> MUTED, mute counter=0.
  - MUTED:
    - cleaning_reminder=0; alert_led=1; usage_s keeps accruing.
    - Mute counter increments on tick. At MUTE_S it goes to ALERT with phase=1 and cadence counter=0.
- clean edge, any state, highest priority:
  - Next cycle: state=COUNTING, usage_s=0, prescaler=0, all counters cleared, outputs 0.
  - Wins over a simultaneous mute edge or threshold crossing.
- Threshold changes:
  - Raising or lowering threshold_s while in ALERT/MUTED does not clear the alert; only a clean edge exits.
  - Lowering it below usage_s in COUNTING alerts the next cycle.
  - threshold_s=0 in COUNTING never alerts.
- A tick and a state change in the same cycle both take effect: usage_s still increments.
- Encoding: COUNTING=2'd0, ALERT=2'd1, MUTED=2'd2. 2'd3 is unreachable and recovers to COUNTING.

Decomposition:
- Shared package: state encodings (COUNTING/ALERT/MUTED) and default constants (TICK_DIV, BEEP_HALF, MUTE_S).
- One sub-module, usage_tick_gen: the fan_on-gated prescaler producing the 1-cycle tick.
- Edge detectors, FSM, cadence and counters stay in the top level.

Test Plan (TICK_DIV=10, BEEP_HALF=4, MUTE_S=3, threshold_s=5):
- Reset held 3 cycles, then fan_on=1 for 49 cycles -> usage_s=4, state COUNTING, cleaning_reminder=0.
- Fan on 50 cycles, then off -> usage_s=5. Next cycle: state ALERT, alert_led=1, cleaning_reminder pattern 1111 0000 1111…, unaffected by fan_on=0.
- In ALERT, mute rising edge -> next cycle cleaning_reminder=0, alert_led=1. After 30 fan_on cycles (3 ticks), state ALERT again and cleaning_reminder=1.
- In ALERT, mute and clean rising in the same cycle -> next cycle state COUNTING, usage_s=0, both outputs 0.
- Set threshold_s=0 and run fan 200 cycles -> usage_s=20, never alerts. Then set threshold_s=15 -> ALERT on the following cycle.
- Force usage_s near saturation (TIME_W=4, threshold_s=0) -> usage_s stops at 15, no wrap. Assert rst_n=0 mid-ALERT -> all outputs 0 on the next clk edge.
